// File: rtl/pattern_player.sv
// pattern_player: replays the stored LED pattern, one RAM entry per step, paced by blink_clk edges.
// Latency: start -> RAM read strobe next cycle, first LED lit three cycles after start.
// Backpressure: none; start is ignored while busy, abort cancels at once. Option: PATTERN_PLAYER_SPEEDUP_EN.
module pattern_player #(
  parameter int NUM_LEDS    = 4,
  parameter int IDX_W       = 2,
  parameter int ADDR_W      = 5,
  parameter int ON_TICKS    = 1,
  parameter int OFF_TICKS   = 1,
  parameter int FAST_THRESH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blink_clk,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W:0]     seq_len,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [IDX_W-1:0]    rd_data,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic                done
);

  localparam int LEN_W     = ADDR_W + 1;
  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, SHOW, GAP, DONE} stateT;

  stateT               state, stateNext;
  logic [ADDR_W-1:0]   step, stepNext;
  logic [LEN_W-1:0]    lenQ, lenNext;
  logic [IDX_W-1:0]    idxQ, idxNext;
  logic [CNT_W-1:0]    tickCnt, cntNext;
  logic [NUM_LEDS-1:0] ledNext;
  logic                blinkD;
  logic                tick;

  // blink_clk is only ever a data input; its edges become single-cycle ticks.
`ifdef PATTERN_PLAYER_SPEEDUP_EN
  logic fastMode;
  assign fastMode = (int'(lenQ) >= FAST_THRESH);
  assign tick     = fastMode ? (blink_clk ^ blinkD) : (blink_clk & ~blinkD);
`else
  // FAST_THRESH only influences the speed-up build.
  logic unusedFastThresh;
  assign unusedFastThresh = (FAST_THRESH != 0);
  assign tick             = blink_clk & ~blinkD;
`endif

  // Next-state logic: abort outranks everything, including a start in IDLE.
  always_comb begin
    stateNext = state;
    stepNext  = step;
    lenNext   = lenQ;
    idxNext   = idxQ;
    cntNext   = tickCnt;
    if (abort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lenNext   = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
            stepNext  = '0;
            stateNext = (seq_len == '0) ? DONE : FETCH;
          end
        end
        FETCH:     stateNext = WAIT_DATA;
        WAIT_DATA: begin
          idxNext   = rd_data;
          cntNext   = '0;
          stateNext = SHOW;
        end
        SHOW: begin
          if (tick) begin
            if (tickCnt == CNT_W'(ON_TICKS - 1)) begin
              cntNext   = '0;
              stateNext = GAP;
            end else begin
              cntNext = tickCnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (tickCnt == CNT_W'(OFF_TICKS - 1)) begin
              cntNext = '0;
              // len_q is one bit wider than step, so the last step is reached without wrapping.
              if ({1'b0, step} == lenQ - 1'b1) begin
                stateNext = DONE;
              end else begin
                stepNext  = step + 1'b1;
                stateNext = FETCH;
              end
            end else begin
              cntNext = tickCnt + 1'b1;
            end
          end
        end
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // LED pattern for the coming cycle; out-of-range indices leave every LED dark.
  always_comb begin
    ledNext = '0;
    if (stateNext == SHOW) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        ledNext[i] = (int'(idxNext) == i);
      end
    end
  end

  // State, step bookkeeping and blink edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      lenQ    <= '0;
      idxQ    <= '0;
      tickCnt <= '0;
      blinkD  <= 1'b1;
    end else begin
      state   <= stateNext;
      step    <= stepNext;
      lenQ    <= lenNext;
      idxQ    <= idxNext;
      tickCnt <= cntNext;
      blinkD  <= blink_clk;
    end
  end

  // Outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_en   <= (stateNext == FETCH);
      rd_addr <= stepNext;
      led     <= ledNext;
      busy    <= (stateNext != IDLE);
      done    <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: small-configuration instance, behavioural playback model, directed scenarios.
module tb_pattern_player;

  localparam int NL  = 3;
  localparam int IW  = 2;
  localparam int AW  = 2;
  localparam int ON  = 2;
  localparam int OFF = 3;
  localparam int FT  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          blink_clk = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   seq_len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data = '0;
  logic [NL-1:0] led;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] ram [0:(1<<AW)-1];
  int blinkCnt  = 0;
  bit blinkHold = 1'b1;
  bit cmpOn     = 1'b0;

  pattern_player #(
    .NUM_LEDS(NL), .IDX_W(IW), .ADDR_W(AW),
    .ON_TICKS(ON), .OFF_TICKS(OFF), .FAST_THRESH(FT)
  ) dut (
    .clk(clk), .rst(rst), .blink_clk(blink_clk), .start(start), .abort(abort),
    .seq_len(seq_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pattern RAM with synchronous read.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // Blink source: toggles every 4 clk, or held high on request.
  always @(negedge clk) begin
    blinkCnt++;
    blink_clk = blinkHold ? 1'b1 : blinkCnt[2];
  end

  // Behavioural model: playback as a list of steps, each a load, a lit budget and a dark budget in ticks.
  bit            mPlaying, mFinishing, mPrev;
  int            mLoad, mLit, mDark, mStep, mLen, mIdx;
  logic [NL-1:0] eLed;
  bit            eBusy, eDone, eRdEn;
  int            eAddr;

  always @(posedge clk) begin : modelProc
    bit tk;
    tk = blink_clk && !mPrev;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
    if (mLen >= FT) tk = (blink_clk != mPrev);
`endif
    if (rst) begin
      mPlaying = 0; mFinishing = 0; mPrev = 1; mLoad = 0; mLit = 0; mDark = 0;
      mStep = 0; mLen = 0; mIdx = 0;
    end else begin
      mPrev = blink_clk;
      if (abort) begin
        mPlaying = 0; mFinishing = 0; mLoad = 0; mLit = 0; mDark = 0;
      end else if (mFinishing) begin
        mFinishing = 0;
      end else if (!mPlaying) begin
        if (start) begin
          mLen  = (int'(seq_len) > (1 << AW)) ? (1 << AW) : int'(seq_len);
          mStep = 0;
          if (mLen == 0) mFinishing = 1;
          else begin mPlaying = 1; mLoad = 2; end
        end
      end else if (mLoad == 2) begin
        mLoad = 1;
      end else if (mLoad == 1) begin
        mLoad = 0; mIdx = int'(rd_data); mLit = ON;
      end else if (mLit > 0) begin
        if (tk) begin mLit--; if (mLit == 0) mDark = OFF; end
      end else if (tk) begin
        mDark--;
        if (mDark == 0) begin
          if (mStep == mLen - 1) begin mPlaying = 0; mFinishing = 1; end
          else begin mStep++; mLoad = 2; end
        end
      end
    end
    eBusy = mPlaying || mFinishing;
    eDone = mFinishing;
    eRdEn = mPlaying && (mLoad == 2);
    eAddr = mStep;
    eLed  = '0;
    if (mPlaying && mLoad == 0 && mLit > 0 && mIdx < NL) eLed[mIdx] = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmpOn) begin
      checks++;
      if (busy !== eBusy || done !== eDone || led !== eLed || rd_en !== eRdEn ||
          (eRdEn && rd_addr !== AW'(eAddr))) begin
        errors++;
        $display("FAIL model t=%0t busy=%b want %b done=%b want %b led=%b want %b rd_en=%b want %b rd_addr=%0d want %0d",
                 $time, busy, eBusy, done, eDone, led, eLed, rd_en, eRdEn, rd_addr, eAddr);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Playback observation results.
  int litQ[$];
  int addrQ[$];
  int doneCnt, firstRd, firstLed, doneAt, busyAfter, busyAtDone, busyCnt;

  task automatic play(input int len, input int budget, input bit midStart);
    int prevLed;
    litQ.delete(); addrQ.delete();
    doneCnt = 0; firstRd = -1; firstLed = -1; doneAt = -1; busyAfter = -1; busyAtDone = -1;
    busyCnt = 0; prevLed = 0;
    @(negedge clk);
    start = 1'b1; seq_len = (AW+1)'(len);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (midStart && cyc == 6) begin start = 1'b1; seq_len = 1; end
      if (rd_en) addrQ.push_back(int'(rd_addr));
      if (led != 0 && prevLed == 0) litQ.push_back(int'(led));
      prevLed = int'(led);
      if (firstRd < 0 && rd_en) firstRd = cyc;
      if (firstLed < 0 && led != 0) firstLed = cyc;
      if (busy) busyCnt++;
      if (doneAt >= 0 && cyc == doneAt + 1) begin busyAfter = int'(busy); break; end
      if (done) begin doneCnt++; doneAt = cyc; busyAtDone = int'(busy); end
    end
    start = 1'b0;
    check("play_completed", int'(busyAfter >= 0), 1);
  endtask

  initial begin : stim
    bit found;
    ram = '{2'd2, 2'd0, 2'd1, 2'd3};
    @(posedge clk);
    cmpOn = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_led", int'(led), 0);
    check("reset_done", int'(done), 0);
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_rd_addr", int'(rd_addr), 0);

    // Leave reset with blink held high, then let it run.
    rst = 1'b0;
    repeat (5) @(negedge clk);
    blinkHold = 1'b0;
    repeat (3) @(negedge clk);

    // Basic play with a start pulse mid-play that must be ignored.
    play(3, 800, 1'b1);
    check("basic_lit_count", litQ.size(), 3);
    if (litQ.size() == 3) begin
      check("basic_lit0", litQ[0], 4);
      check("basic_lit1", litQ[1], 1);
      check("basic_lit2", litQ[2], 2);
    end
    check("basic_rd_count", addrQ.size(), 3);
    if (addrQ.size() == 3) check("basic_rd_addr2", addrQ[2], 2);
    check("basic_first_rd", firstRd, 1);
    check("basic_first_led", firstLed, 3);
    check("basic_done_count", doneCnt, 1);
    check("basic_busy_at_done", busyAtDone, 1);
    check("basic_busy_after_done", busyAfter, 0);

    // Zero length.
    play(0, 20, 1'b0);
    check("zero_done_at", doneAt, 1);
    check("zero_busy_cycles", busyCnt, 1);
    check("zero_rd_count", addrQ.size(), 0);

    // Full length and clamped length.
    play(4, 800, 1'b0);
    check("full_rd_count", addrQ.size(), 4);
    if (addrQ.size() == 4) check("full_rd_addr3", addrQ[3], 3);
    check("full_lit_count", litQ.size(), 3);
    check("full_done_count", doneCnt, 1);
    play(7, 800, 1'b0);
    check("clamp_rd_count", addrQ.size(), 4);
    if (addrQ.size() == 4) begin
      check("clamp_rd_addr0", addrQ[0], 0);
      check("clamp_rd_addr3", addrQ[3], 3);
    end
    check("clamp_lit_count", litQ.size(), 3);

    // Abort while step 1 is lit.
    @(negedge clk); start = 1'b1; seq_len = 4;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (led == 3'b001) found = 1;
    end
    check("abort_reached_step1", int'(found), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_led", int'(led), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    // abort together with start in IDLE: start ignored.
    abort = 1'b1; start = 1'b1; seq_len = 2;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_start_busy", int'(busy), 0);
    check("abort_start_rd_en", int'(rd_en), 0);
    play(2, 600, 1'b0);
    if (addrQ.size() > 0) check("replay_rd_addr0", addrQ[0], 0);
    check("replay_lit_count", litQ.size(), 2);

    // Reset during the gap of step 1.
    @(negedge clk); start = 1'b1; seq_len = 3;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(negedge clk);
      if (led == 3'b001) found = 1;
    end
    for (int c = 0; c < 200 && found && led != 0; c++) @(negedge clk);
    check("gap_reached", int'(found && led == 0 && busy), 1);
    check("gap_rd_addr", int'(rd_addr), 1);
    rst = 1'b1; blinkHold = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_led", int'(led), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    blinkHold = 1'b0;

    // Single-step sequence below the speed-up threshold.
    play(1, 400, 1'b0);
    check("single_lit_count", litQ.size(), 1);
    if (litQ.size() == 1) check("single_lit0", litQ[0], 4);
    check("single_done_count", doneCnt, 1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Playback sequencer for the memorization game: steps through the stored pattern and lights one LED per step, timed by the blink-rate clock from the divider.
- Sits between the pattern RAM (synchronous read), the divider's blink output, and the LED drivers. The game FSM starts it and waits for done before accepting player input.
- Treats blink_clk as a data signal: samples it in the clk domain and uses its rising edges as timing ticks. blink_clk is never used as a clock.

Parameters:
- NUM_LEDS, 4, number of LEDs; led output width.
- IDX_W, 2, width of one stored pattern entry (LED index).
- ADDR_W, 5, pattern RAM address width; maximum sequence length is 2^ADDR_W.
- ON_TICKS, 1, blink ticks an LED stays lit per step (≥1).
- OFF_TICKS, 1, blink ticks of dark gap after each step (≥1).
- FAST_THRESH, 8, seq_len at or above which speed-up applies (optional feature only).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- blink_clk  in  1  divider blink output (2 Hz square wave), sampled as data.
- start  in  1  one-cycle pulse; begin playback.
- abort  in  1  level; cancel playback.
- seq_len  in  ADDR_W+1  number of steps to play; latched on an accepted start.
- rd_en  out  1  pattern RAM read strobe.
- rd_addr  out  ADDR_W  pattern RAM address (current step).
- rd_data  in  IDX_W  RAM data; valid exactly 1 cycle after rd_en.
- led  out  NUM_LEDS  one-hot LED drive.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when playback completes normally.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst. All logic updates on posedge clk only.
- Tick detection: blink_d is a 1-bit register of blink_clk. tick = blink_clk & ~blink_d. blink_d resets to 1, so no spurious tick can occur when leaving reset.
- Reset values: led=0, busy=0, done=0, rd_en=0, rd_addr=0, step=0, tick_cnt=0, state=IDLE. Reset mid-playback aborts immediately with no done pulse.
- States: IDLE, FETCH, WAIT_DATA, SHOW, GAP, DONE.
- IDLE:
  - start=1 latches seq_len into len_q and clears step.
  - If seq_len=0, go to DONE. Otherwise go to FETCH.
  - start in any other state is ignored.
- FETCH (1 cycle): rd_en=1, rd_addr=step. Go to WAIT_DATA.
- WAIT_DATA (1 cycle): capture rd_data into idx_q. Go to SHOW and clear tick_cnt.
- SHOW:
  - led = one-hot(idx_q). If idx_q ≥ NUM_LEDS, led = 0 for this step; timing is unchanged.
  - Each tick increments tick_cnt. The tick on which tick_cnt = ON_TICKS-1 moves to GAP and clears tick_cnt.
- GAP:
  - led = 0.
  - The tick on which tick_cnt = OFF_TICKS-1 does one of two things:
    - if step = len_q-1, go to DONE;
    - otherwise step increments and the state goes to FETCH.
- DONE (1 cycle): done=1, led=0. Go to IDLE.
- Latency:
  - start at cycle N: FETCH at N+1, WAIT_DATA at N+2, led valid at N+3.
  - The first SHOW interval is therefore partial: it ends on the ON_TICKS-th tick after entry.
- Ticks arriving in FETCH, WAIT_DATA, DONE or IDLE are ignored and not queued.
- abort: checked at top priority after rst. In any non-IDLE state, go to IDLE next cycle with led=0, busy=0 and no done.
- Simultaneous events: abort together with start in IDLE means start is ignored. Abort together with the final GAP tick means abort wins and done is not pulsed.
- Width rules:
  - step is ADDR_W bits. len_q is ADDR_W+1 bits, so 2^ADDR_W steps are legal.
  - seq_len > 2^ADDR_W is clamped to 2^ADDR_W on latch.
  - step never wraps during playback.
- busy is a registered decode of state; done is registered.

Optional Feature:
- Macro: PATTERN_PLAYER_SPEEDUP_EN.
- Defined:
  - if len_q ≥ FAST_THRESH, ticks are both edges of blink_clk: tick = blink_clk ^ blink_d. This doubles playback speed for long sequences.
  - Below FAST_THRESH, behaviour is unchanged.
- Undefined: rising edges only, always. FAST_THRESH has no effect.

Test Plan:
- Basic play: drive blink_clk toggling every 4 clk; RAM = {2,0,3}; start with seq_len=3 -> led sequence 0100, 0000, 0001, 0000, 1000, 0000. Each lit/dark phase ends on a rising edge; done pulses once; busy falls on the cycle after done.
- Zero length: start with seq_len=0 -> done at N+1, busy high only during that cycle, rd_en never asserted.
- Abort: abort while led=0001 in SHOW of step 1 of 4 -> next cycle led=0, busy=0, no done; a later start replays from rd_addr=0.
- Reset edge cases: hold blink_clk=1 through rst release -> no tick counted. Start during busy -> ignored and len_q unchanged. Assert rst mid-GAP -> all outputs at reset values next cycle.
- Full length and bounds: ADDR_W=2, seq_len=4 then seq_len=7 -> both play exactly 4 steps, rd_addr 0..3, no wrap. An entry with idx ≥ NUM_LEDS (NUM_LEDS=3, idx=3) -> led=0 for a full-length step.
- Speed-up: with PATTERN_PLAYER_SPEEDUP_EN, FAST_THRESH=2, seq_len=2 -> each phase ends on the next edge of either polarity. With seq_len=1 -> rising edges only.
